// File: rtl/adc_fifo_uart_reader_if.sv
`default_nettype none
// ============================================================================
// Module      : adc_fifo_uart_reader_if
// Description : Bus bundle for the ADC FIFO read-side UART streamer. Groups
//               the burst control, FIFO read handshake and serial outputs.
//               master = the reader itself, slave = its environment.
// Revision    : 1.0 - initial release
// ============================================================================
interface adc_fifo_uart_reader_if #(
    parameter int PRECISION = 10,
    parameter int CNT_WIDTH = 12
);
    logic                 start;
    logic                 fifo_empty;
    logic [PRECISION-1:0] fifo_dout;
    logic                 rd_en;
    logic                 uart_tx;
    logic                 busy;
    logic                 done;
    logic [CNT_WIDTH-1:0] samples_sent;

    modport master (
        input  start, fifo_empty, fifo_dout,
        output rd_en, uart_tx, busy, done, samples_sent
    );

    modport slave (
        output start, fifo_empty, fifo_dout,
        input  rd_en, uart_tx, busy, done, samples_sent
    );
endinterface
`default_nettype wire

// File: rtl/adc_fifo_uart_reader.sv
`default_nettype none
// ============================================================================
// Module      : adc_fifo_uart_reader
// Description : On a start pulse sends header 0xA5, then drains SAMPLE_COUNT
//               ADC codes from the capture FIFO and sends each one as two
//               UART 8N1 bytes (tagged high byte first, then low byte).
// Revision    : 1.0 - initial release
// ============================================================================
module adc_fifo_uart_reader #(
    parameter int PRECISION    = 10,
    parameter int CLKS_PER_BIT = 868,
    parameter int SAMPLE_COUNT = 1024,
    parameter int CNT_WIDTH    = 12
) (
    input  wire                    clk,
    input  wire                    rst_n,
    adc_fifo_uart_reader_if.master bus
);

    localparam int                   c_baud_w       = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_baud_w-1:0]  c_baud_last    = c_baud_w'(CLKS_PER_BIT - 1);
    localparam logic [CNT_WIDTH-1:0] c_sample_count = CNT_WIDTH'(SAMPLE_COUNT);
    localparam logic [7:0]           c_header       = 8'hA5;
    localparam logic [3:0]           c_last_data    = 4'd8;
    localparam logic [3:0]           c_stop_bit     = 4'd9;

    localparam logic [2:0] c_st_idle    = 3'd0;
    localparam logic [2:0] c_st_hdr     = 3'd1;
    localparam logic [2:0] c_st_fetch   = 3'd2;
    localparam logic [2:0] c_st_capture = 3'd3;
    localparam logic [2:0] c_st_tx_hi   = 3'd4;
    localparam logic [2:0] c_st_tx_lo   = 3'd5;
    localparam logic [2:0] c_st_done    = 3'd6;

    logic [2:0]           r_state;
    logic [c_baud_w-1:0]  r_baud;
    logic [3:0]           r_bit_idx;     // 0 = start, 1..8 = data, 9 = stop
    logic [7:0]           r_byte;
    logic                 r_tx;
    logic [7:0]           r_sample_lo;   // low byte kept for the second frame
    logic [CNT_WIDTH-1:0] r_samples_sent;

    logic [7:0]           w_hi_byte;
    logic                 w_tx_active;
    logic                 w_byte_end;
    logic [CNT_WIDTH-1:0] w_sent_inc;

    // High byte: bit7 flags the upper half, code MSBs right-aligned below zeros
    always_comb begin
        w_hi_byte                  = 8'h80;
        w_hi_byte[PRECISION-9:0]   = bus.fifo_dout[PRECISION-1:8];
    end

    assign w_tx_active = (r_state == c_st_hdr) || (r_state == c_st_tx_hi) ||
                         (r_state == c_st_tx_lo);
    assign w_byte_end  = (r_baud == c_baud_last) && (r_bit_idx == c_stop_bit);
    assign w_sent_inc  = r_samples_sent + 1'b1;

    // Burst sequencer and bit-serial transmitter sharing one set of counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= c_st_idle;
            r_baud         <= '0;
            r_bit_idx      <= '0;
            r_byte         <= '0;
            r_tx           <= 1'b1;
            r_sample_lo    <= '0;
            r_samples_sent <= '0;
        end else begin
            // Bit timing; the state cases below override it on frame boundaries
            if (w_tx_active) begin
                if (r_baud == c_baud_last) begin
                    r_baud <= '0;
                    if (r_bit_idx != c_stop_bit) begin
                        r_bit_idx <= r_bit_idx + 4'd1;
                        r_tx      <= (r_bit_idx == c_last_data) ? 1'b1 : r_byte[r_bit_idx[2:0]];
                    end
                end else begin
                    r_baud <= r_baud + 1'b1;
                end
            end

            case (r_state)
                c_st_idle: begin
                    if (bus.start) begin
                        r_state        <= c_st_hdr;
                        r_samples_sent <= '0;
                        r_byte         <= c_header;
                        r_tx           <= 1'b0;
                        r_bit_idx      <= '0;
                        r_baud         <= '0;
                    end
                end
                c_st_hdr: begin
                    if (w_byte_end) begin
                        r_state   <= c_st_fetch;
                        r_bit_idx <= '0;
                    end
                end
                c_st_fetch: begin
                    if (!bus.fifo_empty) begin
                        r_state <= c_st_capture;
                    end
                end
                c_st_capture: begin
                    // FIFO data is valid now, one cycle after the read strobe
                    r_sample_lo <= bus.fifo_dout[7:0];
                    r_byte      <= w_hi_byte;
                    r_tx        <= 1'b0;
                    r_bit_idx   <= '0;
                    r_baud      <= '0;
                    r_state     <= c_st_tx_hi;
                end
                c_st_tx_hi: begin
                    if (w_byte_end) begin
                        r_byte    <= r_sample_lo;
                        r_tx      <= 1'b0;
                        r_bit_idx <= '0;
                        r_baud    <= '0;
                        r_state   <= c_st_tx_lo;
                    end
                end
                c_st_tx_lo: begin
                    if (w_byte_end) begin
                        r_samples_sent <= w_sent_inc;
                        r_bit_idx      <= '0;
                        r_state        <= (w_sent_inc == c_sample_count) ? c_st_done : c_st_fetch;
                    end
                end
                c_st_done: begin
                    r_state <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    // Read strobe lasts exactly the FETCH cycle that sees a non-empty FIFO
    assign bus.rd_en        = (r_state == c_st_fetch) && !bus.fifo_empty;
    assign bus.uart_tx      = r_tx;
    assign bus.busy         = (r_state != c_st_idle) && (r_state != c_st_done);
    assign bus.done         = (r_state == c_st_done);
    assign bus.samples_sent = r_samples_sent;

endmodule
`default_nettype wire

// File: tb/tb_adc_fifo_uart_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_adc_fifo_uart_reader
// Description : Directed bench for adc_fifo_uart_reader. Instance A bursts two
//               samples, instance B one sample; each has a FIFO model and a
//               UART line decoder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adc_fifo_uart_reader;

    localparam int PREC = 10;
    localparam int CPB  = 4;
    localparam int CNTW = 12;

    logic clk = 1'b0;
    logic rst_n_a;
    logic rst_n_b;

    int n_checks = 0;
    int n_fail   = 0;

    logic [PREC-1:0] mem [2][16];
    int wr_ptr [2] = '{0, 0};
    int rd_ptr [2] = '{0, 0};
    int rd_cnt [2] = '{0, 0};
    int done_cnt [2] = '{0, 0};
    int consec_err [2] = '{0, 0};
    int under_err [2] = '{0, 0};
    int done_busy_err [2] = '{0, 0};
    int line_err [2] = '{0, 0};
    logic prev_rd [2] = '{1'b0, 1'b0};
    logic [7:0] q_a [$];
    logic [7:0] q_b [$];

    always #5 clk = ~clk;

    adc_fifo_uart_reader_if #(.PRECISION(PREC), .CNT_WIDTH(CNTW)) bus_a ();
    adc_fifo_uart_reader_if #(.PRECISION(PREC), .CNT_WIDTH(CNTW)) bus_b ();

    adc_fifo_uart_reader #(
        .PRECISION(PREC), .CLKS_PER_BIT(CPB), .SAMPLE_COUNT(2), .CNT_WIDTH(CNTW)
    ) dut_a (
        .clk(clk), .rst_n(rst_n_a), .bus(bus_a)
    );

    adc_fifo_uart_reader #(
        .PRECISION(PREC), .CLKS_PER_BIT(CPB), .SAMPLE_COUNT(1), .CNT_WIDTH(CNTW)
    ) dut_b (
        .clk(clk), .rst_n(rst_n_b), .bus(bus_b)
    );

    assign bus_a.fifo_empty = (wr_ptr[0] == rd_ptr[0]);
    assign bus_b.fifo_empty = (wr_ptr[1] == rd_ptr[1]);

    // FIFO model A: data appears one cycle after the read strobe
    always @(posedge clk) begin
        if (bus_a.rd_en) begin
            if (wr_ptr[0] == rd_ptr[0]) under_err[0] <= under_err[0] + 1;
            else begin
                bus_a.fifo_dout <= mem[0][rd_ptr[0] % 16];
                rd_ptr[0]       <= rd_ptr[0] + 1;
            end
            rd_cnt[0] <= rd_cnt[0] + 1;
            if (prev_rd[0]) consec_err[0] <= consec_err[0] + 1;
        end
        prev_rd[0] <= bus_a.rd_en;
    end

    // FIFO model B
    always @(posedge clk) begin
        if (bus_b.rd_en) begin
            if (wr_ptr[1] == rd_ptr[1]) under_err[1] <= under_err[1] + 1;
            else begin
                bus_b.fifo_dout <= mem[1][rd_ptr[1] % 16];
                rd_ptr[1]       <= rd_ptr[1] + 1;
            end
            rd_cnt[1] <= rd_cnt[1] + 1;
            if (prev_rd[1]) consec_err[1] <= consec_err[1] + 1;
        end
        prev_rd[1] <= bus_b.rd_en;
    end

    // done pulse counting; done must never coincide with busy
    always @(negedge clk) begin
        if (bus_a.done) done_cnt[0] = done_cnt[0] + 1;
        if (bus_b.done) done_cnt[1] = done_cnt[1] + 1;
        if (bus_a.done && bus_a.busy) done_busy_err[0] = done_busy_err[0] + 1;
        if (bus_b.done && bus_b.busy) done_busy_err[1] = done_busy_err[1] + 1;
    end

    function automatic logic tx_of(input int id);
        return (id == 0) ? bus_a.uart_tx : bus_b.uart_tx;
    endfunction

    function automatic logic rst_ok(input int id);
        return (id == 0) ? rst_n_a : rst_n_b;
    endfunction

    function automatic int q_size(input int id);
        return (id == 0) ? q_a.size() : q_b.size();
    endfunction

    function automatic logic [7:0] q_byte(input int id, input int i);
        if (i >= q_size(id)) return 8'hxx;
        return (id == 0) ? q_a[i] : q_b[i];
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Line decoder: every bit must hold for exactly CPB samples
    task automatic uart_mon(input int id);
        logic [9:0] frame;
        logic       aborted;
        int         werr;
        forever begin
            @(negedge clk);
            if (rst_ok(id) && tx_of(id) == 1'b0) begin
                frame   = '0;
                aborted = 1'b0;
                werr    = 0;
                for (int b = 0; b < 10; b++) begin
                    for (int c = 0; c < CPB; c++) begin
                        if (b != 0 || c != 0) @(negedge clk);
                        if (!rst_ok(id)) aborted = 1'b1;
                        if (c == 0) frame[b] = tx_of(id);
                        else if (tx_of(id) != frame[b]) werr++;
                    end
                end
                if (!aborted) begin
                    if (frame[0] != 1'b0 || frame[9] != 1'b1) werr++;
                    line_err[id] += werr;
                    if (id == 0) q_a.push_back(frame[8:1]);
                    else         q_b.push_back(frame[8:1]);
                end
            end
        end
    endtask

    initial uart_mon(0);
    initial uart_mon(1);

    task automatic push(input int id, input logic [PREC-1:0] v);
        mem[id][wr_ptr[id] % 16] = v;
        wr_ptr[id] = wr_ptr[id] + 1;
    endtask

    task automatic pulse_start(input int id);
        if (id == 0) bus_a.start = 1'b1; else bus_b.start = 1'b1;
        @(negedge clk);
        if (id == 0) bus_a.start = 1'b0; else bus_b.start = 1'b0;
    endtask

    task automatic wait_done(input int id, input string tag, input int budget);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            seen = (id == 0) ? bus_a.done : bus_b.done;
        end
        check_val(tag, seen, 1'b1);
    endtask

    task automatic wait_bytes(input int id, input int n, input string tag, input int budget);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            seen = (q_size(id) >= n);
        end
        check_val(tag, seen, 1'b1);
    endtask

    task automatic check_bytes(input int id, input string tag, input logic [7:0] exp[$]);
        check_val({tag, "_count"}, q_size(id), exp.size());
        for (int i = 0; i < exp.size(); i++)
            check_val($sformatf("%s_byte%0d", tag, i), q_byte(id, i), exp[i]);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] exp_q [$];
        int base_rd;
        int base_done;
        int viol;

        rst_n_a = 1'b0;
        rst_n_b = 1'b0;
        bus_a.start = 1'b0;
        bus_b.start = 1'b0;
        repeat (5) @(negedge clk);

        // Reset state
        check_val("rst_tx", bus_a.uart_tx, 1'b1);
        check_val("rst_rd_en", bus_a.rd_en, 1'b0);
        check_val("rst_busy", bus_a.busy, 1'b0);
        check_val("rst_done", bus_a.done, 1'b0);
        check_val("rst_sent", bus_a.samples_sent, 0);
        rst_n_a = 1'b1;
        rst_n_b = 1'b1;

        // Idle after reset with no start
        viol = 0;
        repeat (100) begin
            @(negedge clk);
            if (bus_a.uart_tx !== 1'b1 || bus_a.rd_en !== 1'b0 || bus_a.busy !== 1'b0 ||
                bus_a.done !== 1'b0 || bus_a.samples_sent !== '0) viol++;
            if (bus_b.uart_tx !== 1'b1 || bus_b.rd_en !== 1'b0 || bus_b.busy !== 1'b0 ||
                bus_b.done !== 1'b0 || bus_b.samples_sent !== '0) viol++;
        end
        check_val("idle_100", viol, 0);

        // Normal burst: 0x3FF, 0x155
        push(0, 10'h3FF);
        push(0, 10'h155);
        base_rd   = rd_cnt[0];
        base_done = done_cnt[0];
        pulse_start(0);
        check_val("normal_busy", bus_a.busy, 1'b1);
        wait_done(0, "normal_done_seen", 1000);
        repeat (5) @(negedge clk);
        exp_q = {8'hA5, 8'h83, 8'hFF, 8'h81, 8'h55};
        check_bytes(0, "normal", exp_q);
        check_val("normal_reads", rd_cnt[0] - base_rd, 2);
        check_val("normal_done_cnt", done_cnt[0] - base_done, 1);
        check_val("normal_sent", bus_a.samples_sent, 2);
        check_val("normal_busy_end", bus_a.busy, 1'b0);
        q_a.delete();

        // Underflow stall: one code present, second arrives late
        push(0, 10'h200);
        base_rd   = rd_cnt[0];
        base_done = done_cnt[0];
        pulse_start(0);
        wait_bytes(0, 3, "stall_bytes_seen", 1000);
        viol = 0;
        repeat (200) begin
            @(negedge clk);
            if (bus_a.uart_tx !== 1'b1 || bus_a.rd_en !== 1'b0 || bus_a.busy !== 1'b1) viol++;
        end
        check_val("stall_idle", viol, 0);
        check_val("stall_sent", bus_a.samples_sent, 1);
        check_val("stall_nbytes", q_size(0), 3);
        push(0, 10'h001);
        wait_done(0, "stall_done_seen", 1000);
        repeat (5) @(negedge clk);
        exp_q = {8'hA5, 8'h82, 8'h00, 8'h80, 8'h01};
        check_bytes(0, "stall", exp_q);
        check_val("stall_reads", rd_cnt[0] - base_rd, 2);
        check_val("stall_done_cnt", done_cnt[0] - base_done, 1);
        check_val("stall_sent_end", bus_a.samples_sent, 2);
        q_a.delete();

        // Start pulse during TX_HI must be ignored
        push(0, 10'h3FF);
        push(0, 10'h155);
        base_rd   = rd_cnt[0];
        base_done = done_cnt[0];
        pulse_start(0);
        wait_bytes(0, 1, "ign_hdr_seen", 500);
        repeat (10) @(negedge clk);
        check_val("ign_busy_mid", bus_a.busy, 1'b1);
        pulse_start(0);
        wait_done(0, "ign_done_seen", 1000);
        repeat (80) @(negedge clk);
        exp_q = {8'hA5, 8'h83, 8'hFF, 8'h81, 8'h55};
        check_bytes(0, "ign", exp_q);
        check_val("ign_sent", bus_a.samples_sent, 2);
        check_val("ign_done_cnt", done_cnt[0] - base_done, 1);
        check_val("ign_reads", rd_cnt[0] - base_rd, 2);
        q_a.delete();

        // Asynchronous reset during data bit 3 of the 0x83 frame
        push(0, 10'h3FF);
        push(0, 10'h155);
        pulse_start(0);
        wait_bytes(0, 1, "rst_hdr_seen", 500);
        repeat (20) @(negedge clk);
        check_val("rst_pre_d3", bus_a.uart_tx, 1'b0);
        rst_n_a = 1'b0;
        #1;
        check_val("rst_async_tx", bus_a.uart_tx, 1'b1);
        check_val("rst_async_busy", bus_a.busy, 1'b0);
        repeat (4) @(negedge clk);
        rst_n_a = 1'b1;
        repeat (60) @(negedge clk);
        check_val("rst_after_sent", bus_a.samples_sent, 0);
        check_val("rst_after_tx", bus_a.uart_tx, 1'b1);
        q_a.delete();
        push(0, 10'h0F0);
        base_done = done_cnt[0];
        pulse_start(0);
        wait_done(0, "rst_burst_done_seen", 1000);
        repeat (5) @(negedge clk);
        exp_q = {8'hA5, 8'h81, 8'h55, 8'h80, 8'hF0};
        check_bytes(0, "rst_burst", exp_q);
        check_val("rst_burst_done_cnt", done_cnt[0] - base_done, 1);

        // Back-to-back single-sample bursts on instance B
        push(1, 10'h0AA);
        push(1, 10'h155);
        base_rd   = rd_cnt[1];
        base_done = done_cnt[1];
        pulse_start(1);
        wait_done(1, "b2b_done1_seen", 1000);
        check_val("b2b_sent1", bus_b.samples_sent, 1);
        @(negedge clk);
        pulse_start(1);
        check_val("b2b_clear", bus_b.samples_sent, 0);
        wait_done(1, "b2b_done2_seen", 1000);
        check_val("b2b_sent2", bus_b.samples_sent, 1);
        repeat (5) @(negedge clk);
        exp_q = {8'hA5, 8'h80, 8'hAA, 8'hA5, 8'h81, 8'h55};
        check_bytes(1, "b2b", exp_q);
        check_val("b2b_reads", rd_cnt[1] - base_rd, 2);
        check_val("b2b_done_cnt", done_cnt[1] - base_done, 2);

        // Protocol invariants gathered over the whole run
        for (int id = 0; id < 2; id++) begin
            check_val($sformatf("line_err%0d", id), line_err[id], 0);
            check_val($sformatf("rd_consec%0d", id), consec_err[id], 0);
            check_val($sformatf("rd_empty%0d", id), under_err[id], 0);
            check_val($sformatf("done_busy%0d", id), done_busy_err[id], 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
